// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between a cache fill controller, its cache arrays and main memory.
// master: the fill controller; slave: cache lookup, memory and array side.
interface cache_fill_fsm_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_busy;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_busy,
        input  memory_data,
        input  memory_data_valid,
        output fsm_busy,
        output mem_enable,
        output memory_address,
        output write_data_array,
        output word_index,
        output fill_data,
        output write_tag_array
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_busy,
        output memory_data,
        output memory_data_valid,
        input  fsm_busy,
        input  mem_enable,
        input  memory_address,
        input  write_data_array,
        input  word_index,
        input  fill_data,
        input  write_tag_array
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: eight pipelined word reads per 16-byte block.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start each fill at the missed word.
module cache_fill_fsm #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master bus
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t      state;
    state_t      state_n;
    logic [15:4] base;
    logic [3:0]  req_cnt;
    logic [3:0]  rcv_cnt;
    logic [2:0]  start_off;
    logic [2:0]  miss_off;
    logic [2:0]  req_off;
    logic [2:0]  rcv_off;
    logic        accept;
    logic        unused_addr_bits;

    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != 8) begin : g_bad_cfg
        $error("cache_fill_fsm supports only 8-word blocks");
    end

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    assign miss_off = bus.miss_address[3:1];
`else
    assign miss_off = 3'd0;
`endif

    assign unused_addr_bits = ^bus.miss_address[3:0];

    // Offsets wrap inside the block, so 3-bit adds are exact.
    assign req_off = start_off + req_cnt[2:0];
    assign rcv_off = start_off + rcv_cnt[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            start_off <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                base      <= bus.miss_address[15:4];
                start_off <= miss_off;
                req_cnt   <= '0;
                rcv_cnt   <= '0;
            end else begin
                if (bus.mem_enable) begin
                    req_cnt <= req_cnt + 4'd1;
                end
                if (bus.write_data_array) begin
                    rcv_cnt <= rcv_cnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_n              = state;
        accept               = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.mem_enable       = 1'b0;
        bus.memory_address   = 16'h0000;
        bus.write_data_array = 1'b0;
        bus.word_index       = 3'd0;
        bus.fill_data        = 16'h0000;
        bus.write_tag_array  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.miss_detected && !bus.memory_busy) begin
                    accept  = 1'b1;
                    state_n = FILL;
                end
            end
            FILL: begin
                bus.fsm_busy       = 1'b1;
                bus.mem_enable     = ~req_cnt[3];
                bus.memory_address = {base, req_off, 1'b0};
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    bus.word_index       = rcv_off;
                    bus.fill_data        = bus.memory_data;
                    // Completion is by return count, never by elapsed cycles.
                    if (rcv_cnt == 4'd7) begin
                        bus.write_tag_array = 1'b1;
                        state_n             = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency-4 memory model.
// Honours CACHE_FILL_CRITICAL_WORD_FIRST_EN when building expectations.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_fsm_if bus ();

    cache_fill_fsm #(
        .MEM_LATENCY(4),
        .WORDS_PER_BLOCK(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } req_t;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
        int          cyc;
    } wr_t;

    req_t exp_req[$];
    wr_t  exp_wr[$];
    req_t pend[$];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          wr_seen = 0;
    logic        mon_en = 1'b0;
    logic        exp_busy = 1'b0;
    logic        drop_busy = 1'b0;
    logic        gap_en = 1'b0;
    logic        stray_en = 1'b0;
    logic [15:0] salt = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main memory: each request returns its word four cycles later, in order.
    initial begin
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (pend.size() > 0 && pend[0].cyc <= cyc &&
                (!gap_en || $urandom_range(0, 2) != 0)) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else if (pend.size() == 0 && stray_en &&
                         $urandom_range(0, 1) == 0) begin
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'($urandom);
            end else begin
                bus.memory_data_valid = 1'b0;
                bus.memory_data       = 16'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT requests or writes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (drop_busy) begin
                exp_busy  = 1'b0;
                drop_busy = 1'b0;
            end
            check("fsm_busy", 32'(bus.fsm_busy), 32'(exp_busy));
            if (bus.mem_enable) begin
                pend.push_back('{addr: bus.memory_address, cyc: cyc + 4});
                check("req_expected", 32'(exp_req.size() > 0), 32'd1);
                if (exp_req.size() > 0) begin
                    req_t r;
                    r = exp_req.pop_front();
                    check("req_addr", 32'(bus.memory_address), 32'(r.addr));
                    check("req_cycle", 32'(cyc), 32'(r.cyc));
                end
            end
            if (bus.write_data_array) begin
                check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    wr_seen++;
                    check("word_index", 32'(bus.word_index), 32'(w.idx));
                    check("fill_data", 32'(bus.fill_data), 32'(w.data));
                    check("tag_pulse", 32'(bus.write_tag_array), 32'(w.last));
                    if (w.cyc >= 0) check("write_cycle", 32'(cyc), 32'(w.cyc));
                    if (w.last) drop_busy = 1'b1;
                end
            end else begin
                check("tag_without_write", 32'(bus.write_tag_array), 32'd0);
            end
        end
    end

    task automatic check_zero();
        check("rst_fsm_busy", 32'(bus.fsm_busy), 32'd0);
        check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        check("rst_mem_addr", 32'(bus.memory_address), 32'd0);
        check("rst_write_data", 32'(bus.write_data_array), 32'd0);
        check("rst_word_index", 32'(bus.word_index), 32'd0);
        check("rst_fill_data", 32'(bus.fill_data), 32'd0);
        check("rst_write_tag", 32'(bus.write_tag_array), 32'd0);
    endtask

    task automatic flush();
        exp_req.delete();
        exp_wr.delete();
        exp_busy  = 1'b0;
        drop_busy = 1'b0;
    endtask

    // early: miss is presented in the tag cycle of the previous fill.
    task automatic start_fill(input logic [15:0] a, input int busy_cyc,
                              input bit gaps, input bit early);
        logic [2:0]  off;
        logic [2:0]  k;
        logic [15:0] w;
        int          n;
        gap_en            = gaps;
        bus.miss_detected = 1'b1;
        bus.miss_address  = a;
        bus.memory_busy   = (busy_cyc > 0);
        if (early) tick();
        repeat (busy_cyc) tick();
        bus.memory_busy = 1'b0;
        n = cyc;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        off = a[3:1];
`else
        off = 3'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            k = off + 3'(i);
            w = {a[15:4], k, 1'b0};
            exp_req.push_back('{addr: w, cyc: n + 1 + i});
            exp_wr.push_back('{idx: k, data: mem_word(w), last: (i == 7),
                               cyc: gaps ? -1 : n + 5 + i});
        end
        tick();
        exp_busy         = 1'b1;
        bus.miss_address = 16'hBEEF;
        repeat (3) tick();
        bus.miss_detected = 1'b0;
    endtask

    task automatic wait_writes(input int left);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (exp_wr.size() <= left) return;
        end
        check("fill_timeout", 32'(exp_wr.size()), 32'(left));
        flush();
    endtask

    task automatic settle();
        repeat (2) tick();
        for (int i = 0; i < 100 && pend.size() > 0; i++) tick();
        salt = 16'($urandom);
    endtask

    initial begin
        bit chain;
        bus.miss_detected = 1'b0;
        bus.miss_address  = 16'h0;
        bus.memory_busy   = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_zero();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        start_fill(16'h1234, 0, 1'b0, 1'b0);
        wait_writes(0);
        settle();

        start_fill(16'h1234, 5, 1'b0, 1'b0);
        wait_writes(0);
        settle();

        stray_en = 1'b1;
        repeat (12) tick();
        stray_en = 1'b0;
        settle();

        rst = 1'b1;
        tick();
        tick();
        check_zero();
        rst = 1'b0;
        tick();

        // Abort after the third return; the late returns must be ignored.
        start_fill(16'h5678, 0, 1'b0, 1'b0);
        wait_writes(5);
        rst = 1'b1;
        flush();
        tick();
        rst = 1'b0;
        check_zero();
        settle();

        start_fill(16'hA00E, 0, 1'b0, 1'b0);
        wait_writes(0);
        start_fill(16'h4C72, 2, 1'b0, 1'b1);
        wait_writes(0);
        settle();

        chain = 1'b0;
        for (int t = 0; t < 24; t++) begin
            start_fill(16'($urandom), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), chain);
            wait_writes(0);
            chain = 1'($urandom_range(0, 1));
            if (!chain) settle();
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
